// File: rtl/arm7tdmi_mul_sequencer_pkg.sv
// Shared types and constants for the ARM7TDMI multiply sequencer and multiplier.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    MUL_MUL  = 2'b00,
    MUL_MLA  = 2'b01,
    MUL_MULL = 2'b10,
    MUL_MLAL = 2'b11
  } mul_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXEC  = 2'b01,
    WB_LO = 2'b10,
    WB_HI = 2'b11
  } mul_seq_state_t;

  localparam int MUL_MAX_CYCLES = 6;
  localparam int MUL_CNT_W      = 3;

  function automatic logic is_long_type(mul_type_t t);
    return t[1];
  endfunction

endpackage

// File: rtl/arm7tdmi_mul_sequencer_if.sv
// Sequencer <-> combinational multiplier bus.
interface arm7tdmi_mul_if;
  import arm7tdmi_pkg::*;

  // mul_en high means operands/accumulators are stable this cycle; the multiplier
  // answers combinationally and the sequencer samples results on its last EXEC cycle.
  // There is no backpressure on this bus.
  logic        mul_en;
  mul_type_t   mul_type;
  logic        mul_signed;
  logic        mul_set_flags;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] mul_result_hi;
  logic [31:0] mul_result_lo;
  logic        mul_negative;
  logic        mul_zero;

  modport master (
    output mul_en, mul_type, mul_signed, mul_set_flags,
    output operand_a, operand_b, acc_hi, acc_lo,
    input  mul_result_hi, mul_result_lo, mul_negative, mul_zero
  );

  modport slave (
    input  mul_en, mul_type, mul_signed, mul_set_flags,
    input  operand_a, operand_b, acc_hi, acc_lo,
    output mul_result_hi, mul_result_lo, mul_negative, mul_zero
  );

endinterface

// File: rtl/arm7tdmi_mul_sequencer_cycle_count.sv
// Booth-style early-termination cycle count m (1..4) from Rs.
// ARM7_MUL_EARLY_TERM_EN enables early termination; otherwise m is always 4.
module arm7tdmi_mul_cycle_count (
  input  logic [31:0] rs,
  input  logic        is_long,
  input  logic        is_signed,
  output logic [2:0]  m
);

`ifdef ARM7_MUL_EARLY_TERM_EN
  logic sext_ok;

  // Unsigned long multiplies cannot treat a run of ones as sign extension.
  assign sext_ok = !is_long || is_signed;

  always_comb begin
    m = 3'd4;
    if ((rs[31:24] == 8'h00) || (sext_ok && (&rs[31:24]))) m = 3'd3;
    if ((rs[31:16] == 16'h0000) || (sext_ok && (&rs[31:16]))) m = 3'd2;
    if ((rs[31:8] == 24'h000000) || (sext_ok && (&rs[31:8]))) m = 3'd1;
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{rs, is_long, is_signed};
  assign m = 3'd4;
`endif

endmodule

// File: rtl/arm7tdmi_mul_sequencer.sv
// Multi-cycle control for MUL/MLA/UMULL/SMULL/UMLAL/SMLAL: latch, execute, write back.
// Cycle counts depend on ARM7_MUL_EARLY_TERM_EN (see arm7tdmi_mul_cycle_count).
module arm7tdmi_mul_sequencer
  import arm7tdmi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           instr_mul_type,
  input  logic                 instr_signed,
  input  logic                 instr_set_flags,
  input  logic [3:0]           instr_rd,
  input  logic [3:0]           instr_rn,
  input  logic [31:0]          rm_data,
  input  logic [31:0]          rs_data,
  input  logic [31:0]          rn_data,
  input  logic [31:0]          rd_data,
  output logic                 busy,
  arm7tdmi_mul_if.master       mul,
  output logic                 wb_en,
  output logic [3:0]           wb_addr,
  output logic [31:0]          wb_data,
  output logic                 flag_we,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 done,
  output mul_seq_state_t       state_dbg
);

  mul_seq_state_t        state, state_nxt;
  logic [MUL_CNT_W-1:0]  cnt;
  logic [MUL_CNT_W-1:0]  n_load;
  logic [MUL_CNT_W-1:0]  n_extra;
  logic [2:0]            m;

  mul_type_t   lat_type;
  logic        lat_signed;
  logic        lat_s;
  logic [3:0]  lat_rd;
  logic [3:0]  lat_rn;
  logic [31:0] lat_rm;
  logic [31:0] lat_rs;
  logic [31:0] lat_acc_hi;
  logic [31:0] lat_acc_lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_n;
  logic        res_z;
  logic        final_wb;
  mul_type_t   in_type;

  assign in_type = mul_type_t'(instr_mul_type);

  arm7tdmi_mul_cycle_count u_cycle_count (
    .rs        (rs_data),
    .is_long   (is_long_type(in_type)),
    .is_signed (instr_signed),
    .m         (m)
  );

  // Accumulate forms and long forms each spend extra cycles in the array.
  always_comb begin
    n_extra = 3'd0;
    case (in_type)
      MUL_MUL:  n_extra = 3'd0;
      MUL_MLA:  n_extra = 3'd1;
      MUL_MULL: n_extra = 3'd1;
      MUL_MLAL: n_extra = 3'd2;
      default:  n_extra = 3'd0;
    endcase
    n_load = m + n_extra;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXEC;
      EXEC: begin
        if (abort)          state_nxt = IDLE;
        else if (cnt == 3'd1) state_nxt = WB_LO;
      end
      WB_LO:   state_nxt = is_long_type(lat_type) ? WB_HI : IDLE;
      WB_HI:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_type   <= MUL_MUL;
      lat_signed <= 1'b0;
      lat_s      <= 1'b0;
      lat_rd     <= '0;
      lat_rn     <= '0;
      lat_rm     <= '0;
      lat_rs     <= '0;
      lat_acc_hi <= '0;
      lat_acc_lo <= '0;
      res_hi     <= '0;
      res_lo     <= '0;
      res_n      <= 1'b0;
      res_z      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            cnt        <= n_load;
            lat_type   <= in_type;
            lat_signed <= instr_signed;
            lat_s      <= instr_set_flags;
            lat_rd     <= instr_rd;
            lat_rn     <= instr_rn;
            lat_rm     <= rm_data;
            lat_rs     <= rs_data;
            lat_acc_hi <= rd_data;
            lat_acc_lo <= rn_data;
          end
        end
        EXEC: begin
          cnt <= abort ? '0 : cnt - 3'd1;
          if (!abort && cnt == 3'd1) begin
            res_hi <= mul.mul_result_hi;
            res_lo <= mul.mul_result_lo;
            res_n  <= mul.mul_negative;
            res_z  <= mul.mul_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign final_wb = ((state == WB_LO) && !is_long_type(lat_type)) || (state == WB_HI);

  assign busy              = (state != IDLE);
  assign state_dbg         = state;
  assign mul.mul_en        = (state == EXEC);
  assign mul.mul_type      = lat_type;
  assign mul.mul_signed    = lat_signed;
  assign mul.mul_set_flags = lat_s;
  assign mul.operand_a     = lat_rm;
  assign mul.operand_b     = lat_rs;
  assign mul.acc_hi        = lat_acc_hi;
  assign mul.acc_lo        = lat_acc_lo;

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (state)
      WB_LO: begin
        wb_en   = 1'b1;
        wb_addr = is_long_type(lat_type) ? lat_rn : lat_rd;
        wb_data = res_lo;
      end
      WB_HI: begin
        wb_en   = 1'b1;
        wb_addr = lat_rd;
        wb_data = res_hi;
      end
      default: ;
    endcase
  end

  assign done    = final_wb;
  assign flag_we = final_wb & lat_s;
  assign flag_n  = final_wb & res_n;
  assign flag_z  = final_wb & res_z;

endmodule

// File: tb/tb_arm7tdmi_mul_sequencer.sv
// Randomized scoreboard bench for arm7tdmi_mul_sequencer with a behavioural multiply model.
module tb_arm7tdmi_mul_sequencer;
  import arm7tdmi_pkg::*;

  localparam int W = 72; // {cycle[31:0], addr[3:0], data[31:0], done, flag_we, n, z}

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [1:0]  instr_mul_type;
  logic        instr_signed, instr_set_flags;
  logic [3:0]  instr_rd, instr_rn;
  logic [31:0] rm_data, rs_data, rn_data, rd_data;
  logic        busy, wb_en, flag_we, flag_n, flag_z, done;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  mul_seq_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  arm7tdmi_mul_if mif ();

  arm7tdmi_mul_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .instr_mul_type  (instr_mul_type),
    .instr_signed    (instr_signed),
    .instr_set_flags (instr_set_flags),
    .instr_rd        (instr_rd),
    .instr_rn        (instr_rn),
    .rm_data         (rm_data),
    .rs_data         (rs_data),
    .rn_data         (rn_data),
    .rd_data         (rd_data),
    .busy            (busy),
    .mul             (mif),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .flag_we         (flag_we),
    .flag_n          (flag_n),
    .flag_z          (flag_z),
    .done            (done),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stand-in combinational multiplier driven by the sequencer's operand bus.
  logic [63:0] mp;
  always_comb begin
    mp = 64'd0;
    if (mif.mul_type == MUL_MULL || mif.mul_type == MUL_MLAL) begin
      if (mif.mul_signed)
        mp = 64'(longint'(signed'(mif.operand_a)) * longint'(signed'(mif.operand_b)));
      else
        mp = {32'd0, mif.operand_a} * {32'd0, mif.operand_b};
      if (mif.mul_type == MUL_MLAL) mp = mp + {mif.acc_hi, mif.acc_lo};
      mif.mul_result_hi = mp[63:32];
      mif.mul_result_lo = mp[31:0];
      mif.mul_negative  = mp[63];
      mif.mul_zero      = (mp == 64'd0);
    end else begin
      mp[31:0] = mif.operand_a * mif.operand_b + ((mif.mul_type == MUL_MLA) ? mif.acc_lo : 32'd0);
      mif.mul_result_hi = 32'd0;
      mif.mul_result_lo = mp[31:0];
      mif.mul_negative  = mp[31];
      mif.mul_zero      = (mp[31:0] == 32'd0);
    end
  end

  // Reference: internal cycle count from the numeric range of Rs.
  function automatic int model_m(logic [31:0] rs, bit ext);
    longint v;
`ifdef ARM7_MUL_EARLY_TERM_EN
    v = ext ? longint'(signed'(rs)) : longint'({32'd0, rs});
    if (v >= -256 && v <= 255) return 1;
    if (v >= -65536 && v <= 65535) return 2;
    if (v >= -16777216 && v <= 16777215) return 3;
    return 4;
`else
    v = longint'({32'd0, rs}) + longint'(ext);
    return (v < 0) ? 0 : 4;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [300:0] v;
    v = '0;
    v = {busy, mif.mul_en, mif.mul_type, mif.mul_signed, mif.mul_set_flags,
         mif.operand_a, mif.operand_b, mif.acc_hi, mif.acc_lo,
         wb_en, wb_addr, wb_data, flag_we, flag_n, flag_z, done};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero, got busy=%b wb_en=%b done=%b flag_we=%b op_a=%h op_b=%h expected 0",
               name, busy, wb_en, done, flag_we, mif.operand_a, mif.operand_b);
    end
  endtask

  // Driver: call at a negedge while idle. abort_at>0 aborts in cycle T+abort_at;
  // rst_wblo asserts reset during the WB_LO cycle.
  task automatic issue(input logic [1:0] t, input bit sg, input bit s,
                       input logic [3:0] rd, input logic [3:0] rn,
                       input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input int abort_at, input bit rst_wblo);
    int n, tt, rel, exit_rel;
    bit is_long, ext, fin;
    logic [63:0] p;
    logic n_f, z_f;
    is_long = t[1];
    ext = !is_long || sg;
    n = model_m(rs, ext) + ((t == 2'b00) ? 0 : (t == 2'b11) ? 2 : 1);
    tt = cyc + 1;
    if (is_long) begin
      p = sg ? 64'(longint'(signed'(rm)) * longint'(signed'(rs))) : ({32'd0, rm} * {32'd0, rs});
      if (t == 2'b11) p = p + {hi, lo};
      n_f = p[63];
      z_f = (p == 64'd0);
    end else begin
      p = {32'd0, rm * rs + ((t == 2'b01) ? lo : 32'd0)};
      n_f = p[31];
      z_f = (p[31:0] == 32'd0);
    end
    if (abort_at == 0) begin
      if (is_long) begin
        exp_q.push_back({32'(tt + n), rn, p[31:0], 4'b0000});
        if (!rst_wblo) exp_q.push_back({32'(tt + n + 1), rd, p[63:32], 1'b1, s, n_f, z_f});
      end else begin
        exp_q.push_back({32'(tt + n), rd, p[31:0], 1'b1, s, n_f, z_f});
      end
    end
    exit_rel = (abort_at > 0) ? abort_at : (rst_wblo ? n + 1 : (is_long ? n + 2 : n + 1));
    instr_mul_type = t; instr_signed = sg; instr_set_flags = s;
    instr_rd = rd; instr_rn = rn; rm_data = rm; rs_data = rs; rn_data = lo; rd_data = hi;
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    fin = 0;
    for (int w = 0; w < 40 && !fin; w++) begin
      rel = cyc - tt;
      if (!busy) begin
        fin = 1;
      end else if (rst_wblo && rel == n) begin
        start = 1'b0; abort = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset_in_wb_lo");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
      end else begin
        start = 1'($urandom_range(0, 1));
        instr_mul_type = 2'($urandom); rm_data = $urandom; rs_data = $urandom;
        rn_data = $urandom; rd_data = $urandom; instr_rd = 4'($urandom); instr_rn = 4'($urandom);
        if (abort_at > 0 && rel == abort_at - 1) abort = 1'b1;
        else abort = (rel >= n) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    if (!fin) begin
      errors++;
      checks++;
      $display("FAIL busy_timeout: busy still 1 after 40 cycles, expected 0");
    end else begin
      check("busy_fall_cycle", 64'(cyc - tt), 64'(exit_rel));
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && (wb_en || done || flag_we)) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_wb: got wb_en=%b addr=%h data=%h done=%b expected no activity (cycle %0d)",
                 wb_en, wb_addr, wb_data, done, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wb_cycle", 64'(cyc), 64'(e[71:40]));
        check("wb_en", 64'(wb_en), 64'd1);
        check("wb_addr", 64'(wb_addr), 64'(e[39:36]));
        check("wb_data", 64'(wb_data), 64'(e[35:4]));
        check("done", 64'(done), 64'(e[3]));
        check("flag_we", 64'(flag_we), 64'(e[2]));
        if (e[3]) check("flags_nz", 64'({flag_n, flag_z}), 64'(e[1:0]));
      end
    end
  end

  initial begin
    int kind, ab;
    logic [31:0] rs;
    logic [1:0] t;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    instr_mul_type = 2'b00; instr_signed = 1'b0; instr_set_flags = 1'b0;
    instr_rd = '0; instr_rn = '0; rm_data = '0; rs_data = '0; rn_data = '0; rd_data = '0;
    #1 check_all_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // directed cases
    issue(2'b00, 0, 1, 4'd3, 4'd9, 32'd7, 32'd6, 32'd0, 32'd0, 0, 0);
    issue(2'b11, 0, 0, 4'd5, 4'd4, 32'hFFFFFFFF, 32'd2, 32'd1, 32'd0, 0, 0);
    issue(2'b10, 1, 1, 4'd7, 4'd6, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 0);
    issue(2'b10, 0, 1, 4'd1, 4'd2, 32'h12345678, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 0);
    issue(2'b00, 0, 1, 4'd8, 4'd8, 32'h12345678, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 0);
    issue(2'b01, 0, 1, 4'd2, 4'd3, 32'd10, 32'h00012345, 32'd4, 32'd0, 2, 0);
    issue(2'b00, 0, 1, 4'd4, 4'd0, 32'd0, 32'd99, 32'd0, 32'd0, 0, 0);
    issue(2'b11, 1, 1, 4'd11, 4'd10, 32'hFFFF0000, 32'h00001234, 32'h55, 32'h66, 0, 1);
    check_all_zero("idle_after_mid_reset");
    issue(2'b11, 1, 1, 4'd9, 4'd9, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h2, 0, 0);

    // randomized cases
    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: rs = $urandom_range(0, 255);
        1: rs = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
        2: rs = 32'($urandom_range(0, 65535));
        3: rs = 32'hFFFF0000 | 32'($urandom_range(0, 65535));
        4: rs = {8'h00, 24'($urandom)};
        default: rs = $urandom;
      endcase
      t = 2'($urandom);
      ab = 0;
      if ($urandom_range(0, 9) == 0) ab = 1;
      issue(t, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, rs, $urandom, $urandom, ab, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm7tdmi_mul_sequencer.md
# arm7tdmi_mul_sequencer

Multi-cycle control stage for MUL, MLA, UMULL, SMULL, UMLAL and SMLAL.
- Upstream: accepts a decoded multiply instruction and its register-file operands from decode.
- Execute: holds operands stable on the combinational multiplier for the ARM7TDMI-accurate number of internal cycles, using Rs early termination.
- Downstream: captures the multiplier result and writes it back to the register file (RdLo, then RdHi for long forms) and to the N/Z flags.
- Pipeline: `busy` stalls the pipeline for the whole operation.

## Interface
No parameters.
- `clk` in 1 — core clock
- `rst` in 1 — asynchronous, active-high reset
- `start` in 1 — accept instruction; honoured only when idle
- `abort` in 1 — cancel operation; honoured only in EXEC
- `instr_mul_type` in 2 — 00 MUL, 01 MLA, 10 MULL, 11 MLAL
- `instr_signed` in 1 — signed long multiply; ignored for MUL/MLA
- `instr_set_flags` in 1 — S bit
- `instr_rd` in 4 — Rd (short forms) / RdHi (long forms)
- `instr_rn` in 4 — Rn (MLA) / RdLo (long forms)
- `rm_data`, `rs_data` in 32 each — Rm and Rs values
- `rn_data` in 32 — accumulator low (Rn or RdLo)
- `rd_data` in 32 — accumulator high (RdHi)
- `busy` out 1 — state ≠ IDLE
- `mul_en` out 1 — high throughout EXEC
- `mul_type` out 2, `mul_signed` out 1, `mul_set_flags` out 1 — latched instruction fields
- `operand_a` out 32 = latched Rm; `operand_b` out 32 = latched Rs
- `acc_hi` out 32 = latched RdHi; `acc_lo` out 32 = latched Rn/RdLo
- `mul_result_hi`, `mul_result_lo` in 32 each — from the multiplier
- `mul_negative`, `mul_zero` in 1 each — from the multiplier
- `wb_en` out 1, `wb_addr` out 4, `wb_data` out 32 — register-file write port
- `flag_we` out 1, `flag_n` out 1, `flag_z` out 1 — CPSR N/Z update; C and V are never driven
- `done` out 1 — one-cycle pulse in the final writeback cycle

## Operation
States and transitions:
- IDLE → EXEC on `start`.
- EXEC → WB_LO when the counter reaches 1.
- WB_LO → IDLE for MUL/MLA.
- WB_LO → WB_HI for MULL/MLAL.
- WB_HI → IDLE.

Accept (IDLE with `start`): latch all instruction fields and operand data, load the counter with N.
- N = m for MUL, m+1 for MLA and MULL, m+2 for MLAL.
- m = 1 if Rs[31:8] is all zeros, or all ones when sign-extension applies.
- m = 2 under the same rule applied to Rs[31:16].
- m = 3 under the same rule applied to Rs[31:24].
- m = 4 otherwise.
- All-ones counts as sign-extension for MUL, MLA and signed long forms only. Unsigned long forms test all-zeros only.

EXEC:
- `mul_en` is high; the counter decrements every cycle.
- On the cycle the counter equals 1, capture `mul_result_hi`, `mul_result_lo`, `mul_negative` and `mul_zero` into internal registers.

WB_LO:
- `wb_en` = 1, `wb_data` = captured lo.
- `wb_addr` = `instr_rd` for short forms, `instr_rn` for long forms.

WB_HI:
- `wb_en` = 1, `wb_addr` = `instr_rd`, `wb_data` = captured hi.

Final writeback cycle (WB_LO for short forms, WB_HI for long forms):
- `done` = 1.
- `flag_we` = latched S bit; `flag_n`/`flag_z` = captured flags.

Boundary conditions:
- `start` while busy is ignored. It is not queued.
- `abort` in EXEC → IDLE next cycle with no writeback, no flag update and no `done`.
- `abort` in WB_LO or WB_HI is ignored, so a partial long writeback never occurs.
- Simultaneous `start` and `abort` in IDLE: the start is accepted.
- Rd == Rn is not checked; the writes are issued in the order above.

## Timing
- Reset: state IDLE, counter 0, all latches 0. Every output is 0, including `busy`, `mul_en`, `wb_en`, `flag_we` and `done`.
- Assertion of `rst` mid-operation returns to IDLE immediately, with no further writes.
- `start` is sampled at edge T.
- EXEC occupies cycles T+1 … T+N.
- WB_LO occurs at T+N+1.
- WB_HI occurs at T+N+2 for long forms.
- `busy` falls the cycle after `done`. The next `start` is accepted in that first IDLE cycle.
- Latency from start to `done`: N+1 cycles for short forms, N+2 cycles for long forms.
- All outputs are registered or decoded from state and latches only. There is no combinational path from any input to any output.

## Configuration
- `ARM7_MUL_EARLY_TERM_EN` defined: m is computed from Rs as specified above.
- Undefined: m = 4 for every operand, giving N = 4/5/5/6 for MUL/MLA/MULL/MLAL. Results are identical in both builds; only cycle counts differ.

## Structure
- In `arm7tdmi_pkg`:
  - `mul_type_t`, shared with the multiplier.
  - `mul_seq_state_t` (IDLE, EXEC, WB_LO, WB_HI).
  - Constant `MUL_MAX_CYCLES` = 6.
- Sub-module `arm7tdmi_mul_cycle_count`: combinational, computes m from Rs, the long flag and the signed flag. It contains the macro switch.

## Test plan
- MUL, Rm=7, Rs=6, S=1 → N=1; write 42 to Rd at T+2; `done` at T+2; `flag_we`=1, N=0, Z=0.
- UMLAL, Rm=0xFFFFFFFF, Rs=2, RdHi:RdLo=0:1 → N=3; RdLo←0xFFFFFFFF at T+4; RdHi←0x00000001 at T+5; `done` at T+5.
- SMULL, Rm=5, Rs=0xFFFFFFFF, S=1 → N=2; RdLo←0xFFFFFFFB, RdHi←0xFFFFFFFF; flag N=1, Z=0.
- UMULL, Rs=0xFFFFFFFF → m=4, N=5. MUL with the same Rs → N=1. Without the macro, every case gives m=4.
- MLA, Rs=0x00012345, `abort` at T+2 → IDLE at T+3; no `wb_en`, no `done`. A `start` at T+3 is accepted.
- `rst` asserted during WB_LO of SMLAL → all outputs 0 immediately; no WB_HI.
